// File: rtl/local_store_unit.sv
// Single-port 128-bit local store for quadword loads/stores; zero-fills itself after reset.
// Loads respond LATENCY edges after acceptance; req_ready drops only during INIT and on flush.
module local_store_unit #(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [0:14]  req_addr,
  input  logic [0:127] req_wdata,
  input  logic [0:6]   req_tag,
  input  logic         flush,
  output logic         rsp_valid,
  output logic [0:6]   rsp_tag,
  output logic [0:127] rsp_data,
  output logic         init_done,
  output logic [0:3]   loads_inflight
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  cnt;
  logic [14:0]    addr;
  logic [AW-1:0]  idx;
  logic           unused_addr;
  logic [127:0]   mem [DEPTH];
  logic           mem_we;
  logic [AW-1:0]  mem_idx;
  logic [127:0]   mem_wdat;
  logic           kill;
  logic           load_acc;

  logic [LATENCY:1] vld, vld_nxt;
  logic [6:0]       tag_q [1:LATENCY];
  logic [127:0]     dat_q [1:LATENCY];
  logic [3:0]       inflight_nxt;

  // Quadword index: drop the 4 byte-offset bits, keep the low AW bits of the rest.
  assign addr        = req_addr;
  assign idx         = addr[4 +: AW];
  assign unused_addr = ^addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_wdat  = req_wdata;
    kill      = 1'b0;
    case (state)
      INIT: begin
        mem_we   = 1'b1;
        mem_idx  = cnt;
        mem_wdat = '0;
        if (&cnt) state_nxt = RUN;
      end
      RUN: begin
        req_ready = !flush;
        kill      = flush;
        mem_we    = req_valid && req_we && !flush;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign load_acc = req_valid && req_ready && !req_we;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdat;
  end

  // A flush discards whatever sits in s1..s3; those entries would land in s2..s4.
  always_comb begin
    vld_nxt = {vld[LATENCY-1:1], load_acc};
    if (kill) vld_nxt[4:2] = '0;
  end

  always_comb begin
    inflight_nxt = '0;
    for (int k = 1; k <= LATENCY; k++) inflight_nxt = inflight_nxt + {3'b000, vld_nxt[k]};
  end

  // Payload only moves with a surviving entry, so the last response holds at the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld            <= '0;
      loads_inflight <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      vld            <= vld_nxt;
      loads_inflight <= inflight_nxt;
      if (load_acc) begin
        tag_q[1] <= req_tag;
        dat_q[1] <= mem[idx];
      end
      for (int k = 2; k <= LATENCY; k++) begin
        if (vld_nxt[k]) begin
          tag_q[k] <= tag_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld[LATENCY];
  assign rsp_tag   = tag_q[LATENCY];
  assign rsp_data  = dat_q[LATENCY];
  assign init_done = (state == RUN);

endmodule

// File: tb/tb_local_store_unit.sv
// Bench for local_store_unit: directed table, hand sequences and random traffic against a queue model.
module tb_local_store_unit;

  localparam int DEPTH = 16;
  localparam int LAT   = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_we, flush;
  logic [14:0]  req_addr;
  logic [127:0] req_wdata;
  logic [6:0]   req_tag;
  logic         rsp_valid;
  logic [6:0]   rsp_tag;
  logic [127:0] rsp_data;
  logic         init_done;
  logic [3:0]   loads_inflight;

  local_store_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .init_done(init_done), .loads_inflight(loads_inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         a;
    logic [6:0] tag;
    logic [127:0] dat;
  } pend_t;

  typedef struct {
    logic v, we;
    logic [14:0] addr;
    logic [127:0] wd;
    logic [6:0] tag;
    logic e_vld;
    logic [6:0] e_tag;
    logic [127:0] e_dat;
    logic [3:0] e_inf;
  } vec_t;

  int           n_chk = 0, n_pass = 0;
  int           edge_no = 0, since_rst = 0, max_inf = 0;
  pend_t        pend[$];
  logic [127:0] mem_m [DEPTH];
  logic [6:0]   last_tag;
  logic [127:0] last_dat;
  int           seen_tags[$];
  int           seen_edges[$];
  vec_t         tbl [18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive, check ready, update the model at the edge, check outputs after it.
  task automatic cycle(input logic v, input logic we, input logic [14:0] addr,
                       input logic [127:0] wd, input logic [6:0] tg, input logic fl);
    logic run_m, ev;
    int ef, d, inf, idx;
    logic [6:0] et;
    logic [127:0] ed;
    pend_t e;
    pend_t keep[$];
    req_valid = v; req_we = we; req_addr = addr; req_wdata = wd; req_tag = tg; flush = fl;
    #1;
    run_m = since_rst >= DEPTH;
    chk("req_ready", req_ready, run_m && !fl);
    ef  = edge_no + 1;
    idx = (int'(addr) >> 4) % DEPTH;
    if (run_m && fl) begin
      foreach (pend[k]) if (pend[k].a < ef - 3) keep.push_back(pend[k]);
      pend = keep;
    end
    if (run_m && v && !fl) begin
      if (we) mem_m[idx] = wd;
      else begin
        e.a = ef; e.tag = tg; e.dat = mem_m[idx];
        pend.push_back(e);
      end
    end
    @(posedge clk);
    edge_no++; since_rst++;
    #1;
    ev = 1'b0; et = last_tag; ed = last_dat; inf = 0;
    foreach (pend[k]) begin
      d = edge_no - pend[k].a;
      if (d <= LAT - 1) inf++;
      if (d == LAT - 1) begin ev = 1'b1; et = pend[k].tag; ed = pend[k].dat; end
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_tag", rsp_tag, et);
    chk("rsp_data", rsp_data, ed);
    chk("loads_inflight", loads_inflight, inf);
    chk("init_done", init_done, since_rst >= DEPTH);
    last_tag = et; last_dat = ed;
    keep.delete();
    foreach (pend[k]) if (edge_no - pend[k].a < LAT - 1) keep.push_back(pend[k]);
    pend = keep;
    if (int'(loads_inflight) > max_inf) max_inf = int'(loads_inflight);
    if (rsp_valid) begin
      seen_tags.push_back(int'(rsp_tag));
      seen_edges.push_back(edge_no);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 15'h0, '0, 7'h0, 1'b0);
  endtask

  task automatic do_reset();
    req_valid = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_tag", rsp_tag, 7'h0);
    chk("rst_rsp_data", rsp_data, 128'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_inflight", loads_inflight, 4'h0);
    pend.delete();
    last_tag = '0; last_dat = '0;
    foreach (mem_m[k]) mem_m[k] = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      edge_no++;
      #1;
      chk("rsp_valid_in_reset", rsp_valid, 1'b0);
    end
    reset = 1'b1;
    since_rst = 0;
  endtask

  function automatic vec_t mk(logic v, logic we, logic [14:0] a, logic [127:0] wd, logic [6:0] t,
                              logic ev, logic [6:0] et, logic [127:0] ed, logic [3:0] ei);
    vec_t r;
    r.v = v; r.we = we; r.addr = a; r.wd = wd; r.tag = t;
    r.e_vld = ev; r.e_tag = et; r.e_dat = ed; r.e_inf = ei;
    return r;
  endfunction

  initial begin
    logic [127:0] A5, X, Y, rd;
    A5 = {16{8'hA5}};
    X  = {4{32'h1111_2222}};
    Y  = {4{32'hDEAD_BEEF}};
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_tag = '0; flush = 1'b0;
    #1;
    do_reset();

    // INIT: requests (and flushes) offered every cycle must be refused
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 15'(i * 16), '0, 7'(i), i[0]);

    // every index reads zero after the fill
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 15'(i * 16), '0, 7'(i), 1'b0);
    idle(LAT);

    // store/load and ordering table
    tbl[0]  = mk(1, 1, 15'h0030, A5, 7'd0,  0, 7'd15, '0, 4'd0);
    tbl[1]  = mk(1, 0, 15'h003F, '0, 7'd12, 0, 7'd15, '0, 4'd1);
    tbl[2]  = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd15, '0, 4'd1);
    tbl[3]  = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd15, '0, 4'd1);
    tbl[4]  = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd15, '0, 4'd1);
    tbl[5]  = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd15, '0, 4'd1);
    tbl[6]  = mk(0, 0, 15'h0,    '0, 7'd0,  1, 7'd12, A5, 4'd1);
    tbl[7]  = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd12, A5, 4'd0);
    tbl[8]  = mk(1, 1, 15'h0020, X,  7'd0,  0, 7'd12, A5, 4'd0);
    tbl[9]  = mk(1, 0, 15'h0020, '0, 7'd3,  0, 7'd12, A5, 4'd1);
    tbl[10] = mk(1, 1, 15'h002C, Y,  7'd0,  0, 7'd12, A5, 4'd1);
    tbl[11] = mk(1, 0, 15'h0020, '0, 7'd4,  0, 7'd12, A5, 4'd2);
    tbl[12] = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd12, A5, 4'd2);
    tbl[13] = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd12, A5, 4'd2);
    tbl[14] = mk(0, 0, 15'h0,    '0, 7'd0,  1, 7'd3,  X,  4'd2);
    tbl[15] = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd3,  X,  4'd1);
    tbl[16] = mk(0, 0, 15'h0,    '0, 7'd0,  1, 7'd4,  Y,  4'd1);
    tbl[17] = mk(0, 0, 15'h0,    '0, 7'd0,  0, 7'd4,  Y,  4'd0);
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].tag, 1'b0);
      chk($sformatf("tbl%0d_vld", i), rsp_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_tag", i), rsp_tag, tbl[i].e_tag);
      chk($sformatf("tbl%0d_dat", i), rsp_data, tbl[i].e_dat);
      chk($sformatf("tbl%0d_inf", i), loads_inflight, tbl[i].e_inf);
    end

    // streaming: six back-to-back loads
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 15'((4 + i) * 16), {4{$urandom}}, 7'd0, 1'b0);
    max_inf = 0; seen_tags.delete(); seen_edges.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 15'((4 + i) * 16), '0, 7'(i + 1), 1'b0);
    idle(LAT + 1);
    chk("stream_peak", max_inf, 6);
    chk("stream_drain", loads_inflight, 4'd0);
    chk("stream_count", seen_tags.size(), 6);
    if (seen_tags.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("stream_tag%0d", i), seen_tags[i], i + 1);
      chk("stream_back_to_back", seen_edges[5] - seen_edges[0], 5);
    end

    // flush kills the three youngest of five loads
    seen_tags.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 15'((10 + i) * 16), '0, 7'(20 + i), 1'b0);
    chk("pre_flush_inf", loads_inflight, 4'd5);
    cycle(1'b1, 1'b0, 15'h00F0, '0, 7'd25, 1'b1);
    chk("flush_inf_drop", loads_inflight, 4'd2);
    idle(LAT + 1);
    chk("flush_resp_count", seen_tags.size(), 2);
    if (seen_tags.size() == 2) begin
      chk("flush_resp0", seen_tags[0], 20);
      chk("flush_resp1", seen_tags[1], 21);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 15'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 7'($urandom), $urandom_range(0, 9) == 0);
    idle(LAT + 1);

    // reset with three loads in flight, then the fill re-runs
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 15'(i * 16), '0, 7'(40 + i), 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 15'h0030, '0, 7'd50, 1'b0);
    cycle(1'b1, 1'b0, 15'h0030, '0, 7'd51, 1'b0);
    idle(LAT);
    rd = rsp_data;
    chk("post_reset_tag", rsp_tag, 7'd51);
    chk("post_reset_zero", rd, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/local_store_unit.md
# local_store_unit

Single-port 128-bit local store that serves the odd pipe's quadword load/store requests. On reset it zero-fills the array, then accepts one load or store per cycle. Loads return data through a fixed-latency pipeline tagged with the destination register. A branch flush kills young in-flight loads.

## Interface
- `DEPTH`, 2048: number of 128-bit quadwords; power of two, 16..2048.
- `LATENCY`, 6: edges from request acceptance to response sample; range 4..8.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted at an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store quadword, 0 = load quadword.
- `req_addr` in [0:14]: byte address. Low 4 bits are ignored (16-byte aligned). Index = `req_addr[0:10]` mod `DEPTH`.
- `req_wdata` in [0:127]: store data.
- `req_tag` in [0:6]: destination register for loads; ignored for stores.
- `flush` in 1: branch flush, level-sampled at each edge.
- `rsp_valid` out 1: load response valid, one cycle per load.
- `rsp_tag` out [0:6]: tag of the returned load.
- `rsp_data` out [0:127]: loaded quadword.
- `init_done` out 1: zero-fill complete.
- `loads_inflight` out [0:3]: count of valid loads in stages s1..sLATENCY.

## Operation
- States: INIT → RUN. There is no path back to INIT except through `reset`.
- **INIT**
  - An index counter runs 0..DEPTH-1 and writes 0 to `mem[cnt]` on each edge.
  - After the edge that writes DEPTH-1: state becomes RUN and `init_done` = 1.
  - `req_ready` = 0 throughout INIT.
- **RUN**
  - `req_ready` = !`flush` (combinational). No other backpressure. The response side has no ready signal; writeback always accepts.
- **Store**, on accept edge:
  - `mem[idx]` ← `req_wdata`.
  - Nothing enters the pipeline and no response is produced.
- **Load**, on accept edge:
  - s1 ← {valid = 1, tag, `mem[idx]`}. Data is read from the array state before this edge.
  - A load accepted at the edge after a store to the same index returns the stored data.
  - A store accepted after a load never alters that load's data.
- **Pipeline**: registers s1..sLATENCY shift by one stage every edge. The outputs `rsp_*` are driven directly from sLATENCY.
- **Flush edge** (`flush` = 1 in RUN):
  - No request is accepted.
  - Entries in s1, s2, s3 are discarded: s1..s4 all become invalid after the edge.
  - s4..s(LATENCY-1) shift normally into s5..sLATENCY and complete.
  - Stores already written stay written.
  - `flush` during INIT is ignored.
- **`loads_inflight`**: registered count, updated every edge.
  - +1 for an accepted load.
  - −1 for a valid entry leaving sLATENCY.
  - −(number of killed entries) on a flush edge.
  - Never underflows.
- **Reset** (`reset` = 0, any time, including mid-INIT or mid-load):
  - All stage valid bits clear; in-flight loads are lost with no response.
  - State = INIT, counter = 0.
  - Array contents are undefined until the zero-fill re-runs.
- **Reset values**: `req_ready` 0, `rsp_valid` 0, `rsp_tag` 0, `rsp_data` 0, `init_done` 0, `loads_inflight` 0.
- `rsp_tag` and `rsp_data` hold their last value while `rsp_valid` = 0.

## Timing
- Reset deassert → first INIT write at the first edge → `init_done` = 1 after DEPTH edges. The first request can be accepted at edge DEPTH+1.
- Load accepted at edge E0:
  - `rsp_*` update after edge E0+LATENCY-1.
  - The consumer samples the response at edge E0+LATENCY (6 by default).
- Throughput: 1 request per cycle. Back-to-back loads produce back-to-back responses in order.
- Killed window for a flush at edge Ef: loads accepted at Ef-1, Ef-2, Ef-3.

## Test plan
- **Reset/init**, DEPTH=16: hold reset low 3 cycles, release.
  - `init_done` rises after 16 edges; `req_ready` is 0 before that.
  - Loading every index returns 0.
- **Store then load**:
  - Store 128'hA5…A5 at addr 15'h0030, then load with tag 7'd12 on the next cycle.
  - `rsp_valid` for exactly 1 cycle, sampled 6 edges after the load accept, with tag 12 and data A5…A5.
  - Addr 15'h003F hits the same index.
- **Streaming**: 6 back-to-back loads with tags 1..6 from distinct preset indices.
  - Six consecutive response cycles in order.
  - `loads_inflight` peaks at 6 and returns to 0.
- **Flush**: loads accepted at 5 consecutive edges E..E+4, then `flush` at E+5.
  - Loads E+2..E+4 never respond; loads E and E+1 respond normally.
  - `req_ready` = 0 during the flush cycle.
  - `loads_inflight` drops by 3.
- **Ordering**: load idx 2 (old value X), then store Y to idx 2 on the next cycle.
  - The load returns X; a later load returns Y.
- **Reset mid-operation**: assert reset with 3 loads in flight.
  - No `rsp_valid` pulse; all outputs equal their reset values immediately.
  - INIT re-runs.
